// File: rtl/memcfg_seq.sv
`timescale 1ns/1ps
// memcfg_seq -- memory map configuration command initiator.
//
// On start, walks a contiguous range of logical pages and issues one
// configuration transaction per page (ad15=1, s_ strobed low) mapping it to
// successive physical frame words. Each transaction is handshaken against
// cok with a bounded wait on both the rising and the falling edge of cok.
// Progress (mapped) and the first failure (err, err_page) are reported.
//
// Ports:
//   clk, reset               clock; asynchronous active-high reset
//   start                    one-cycle run request (honoured in IDLE only)
//   abort                    stop the run at the next handshake-safe point
//   first_page[7:0]          first logical page of the run
//   first_frame[7:0]         {module[3:0], frame[3:0]} for the first page
//   count[7:0]               number of pages to walk
//   cok                      responder acknowledge
//   s_                       active-low bus strobe
//   ad15                     configuration qualifier, high while presenting
//   cfg_page[7:0]            page of the command being presented
//   cfg_frame[7:0]           frame word of the command being presented
//   busy, done               run in progress / run finished (sticky)
//   err[1:0]                 00 ok, 01 strobe timeout, 10 release timeout,
//                            11 aborted (sticky like done)
//   err_page[7:0]            page being handled when err was raised
//   mapped[7:0]              pages acknowledged in the current/last run
module memcfg_seq #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] first_page,
  input  logic [7:0] first_frame,
  input  logic [7:0] count,
  input  logic       cok,
  output logic       s_,
  output logic       ad15,
  output logic [7:0] cfg_page,
  output logic [7:0] cfg_frame,
  output logic       busy,
  output logic       done,
  output logic [1:0] err,
  output logic [7:0] err_page,
  output logic [7:0] mapped
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_STROBE  = 3'd2;
  localparam logic [2:0] ST_RELEASE = 3'd3;
  localparam logic [2:0] ST_DRAIN   = 3'd4;
  localparam logic [2:0] ST_NEXT    = 3'd5;
  localparam logic [2:0] ST_FIN     = 3'd6;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_STROBE  = 2'b01;
  localparam logic [1:0] ERR_RELEASE = 2'b10;
  localparam logic [1:0] ERR_ABORT   = 2'b11;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [2:0] state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [7:0] page_q, page_d;
  logic [7:0] frame_q, frame_d;
  logic [7:0] remaining_q, remaining_d;
  logic       abort_pend_q, abort_pend_d;
  logic       s_q, s_d;
  logic       ad15_q, ad15_d;
  logic [7:0] cfg_page_q, cfg_page_d;
  logic [7:0] cfg_frame_q, cfg_frame_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [1:0] err_q, err_d;
  logic [7:0] err_page_q, err_page_d;
  logic [7:0] mapped_q, mapped_d;
  logic       timed_out;

  assign timed_out = (timer_q == TIMEOUT_C);

  always_comb begin
    // NOTE: every _d starts as its _q so no path through this block leaves a
    // variable unassigned; otherwise synthesis would infer a latch.
    state_d      = state_q;
    timer_d      = timer_q;
    page_d       = page_q;
    frame_d      = frame_q;
    remaining_d  = remaining_q;
    abort_pend_d = abort_pend_q;
    s_d          = s_q;
    ad15_d       = ad15_q;
    cfg_page_d   = cfg_page_q;
    cfg_frame_d  = cfg_frame_q;
    busy_d       = busy_q;
    done_d       = done_q;
    err_d        = err_q;
    err_page_d   = err_page_q;
    mapped_d     = mapped_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          page_d       = first_page;
          frame_d      = first_frame;
          remaining_d  = count;
          abort_pend_d = 1'b0;
          done_d       = 1'b0;
          err_d        = ERR_OK;
          err_page_d   = 8'd0;
          mapped_d     = 8'd0;
          busy_d       = 1'b1;
          state_d      = (count == 8'd0) ? ST_FIN : ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (abort) begin
          err_d      = ERR_ABORT;
          err_page_d = page_q;
          state_d    = ST_FIN;
        end else if (page_q < 8'd2) begin
          // Pages 0 and 1 are reserved: skipped silently, frame still advances.
          state_d = ST_NEXT;
        end else begin
          cfg_page_d  = page_q;
          cfg_frame_d = frame_q;
          ad15_d      = 1'b1;
          state_d     = ST_STROBE;
        end
      end

      ST_STROBE: begin
        // The first STROBE cycle still has s_ high; the timeout window is
        // counted from the cycle s_ is actually low.
        timer_d = s_q ? 8'd0 : timer_q + 8'd1;
        s_d     = 1'b0;
        if (cok) begin
          s_d          = 1'b1;
          mapped_d     = mapped_q + 8'd1;
          abort_pend_d = abort_pend_q | abort;
          state_d      = ST_RELEASE;
        end else if (abort) begin
          s_d        = 1'b1;
          err_d      = ERR_ABORT;
          err_page_d = page_q;
          state_d    = ST_DRAIN;
        end else if (!s_q && timed_out) begin
          s_d        = 1'b1;
          err_d      = ERR_STROBE;
          err_page_d = page_q;
          state_d    = ST_DRAIN;
        end
      end

      ST_RELEASE: begin
        // Abort cannot cut a handshake short; remember it for NEXT.
        timer_d      = timer_q + 8'd1;
        abort_pend_d = abort_pend_q | abort;
        if (!cok) begin
          state_d = ST_NEXT;
        end else if (timed_out) begin
          err_d      = ERR_RELEASE;
          err_page_d = page_q;
          state_d    = ST_FIN;
        end
      end

      ST_DRAIN: begin
        timer_d = timer_q + 8'd1;
        if (!cok || timed_out) begin
          state_d = ST_FIN;
        end
      end

      ST_NEXT: begin
        if (abort || abort_pend_q) begin
          err_d      = ERR_ABORT;
          err_page_d = page_q;
          state_d    = ST_FIN;
        end else begin
          remaining_d = remaining_q - 8'd1;
          frame_d     = frame_q + 8'd1;
          page_d      = page_q + 8'd1;
          // Stop at page 0xFF rather than wrapping back to the reserved pages.
          state_d = (remaining_q == 8'd1 || page_q == 8'hFF) ? ST_FIN : ST_SETUP;
        end
      end

      ST_FIN: begin
        ad15_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Every timed state begins its window from zero.
    if (state_d != state_q) begin
      timer_d = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      timer_q      <= 8'd0;
      page_q       <= 8'd0;
      frame_q      <= 8'd0;
      remaining_q  <= 8'd0;
      abort_pend_q <= 1'b0;
      s_q          <= 1'b1;
      ad15_q       <= 1'b0;
      cfg_page_q   <= 8'd0;
      cfg_frame_q  <= 8'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= ERR_OK;
      err_page_q   <= 8'd0;
      mapped_q     <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q      <= state_d;
      timer_q      <= timer_d;
      page_q       <= page_d;
      frame_q      <= frame_d;
      remaining_q  <= remaining_d;
      abort_pend_q <= abort_pend_d;
      s_q          <= s_d;
      ad15_q       <= ad15_d;
      cfg_page_q   <= cfg_page_d;
      cfg_frame_q  <= cfg_frame_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_page_q   <= err_page_d;
      mapped_q     <= mapped_d;
    end
  end

  assign s_        = s_q;
  assign ad15      = ad15_q;
  assign cfg_page  = cfg_page_q;
  assign cfg_frame = cfg_frame_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_page  = err_page_q;
  assign mapped    = mapped_q;

endmodule

// File: tb/tb_memcfg_seq.sv
`timescale 1ns/1ps
// tb_memcfg_seq -- scoreboard bench for memcfg_seq.
// A responder model acknowledges strobes after a programmable latency. Each
// run's expected commands and final status are derived from the page-walk
// rules and queued; a monitor pops and compares as the DUT strobes and
// reports done.
module tb_memcfg_seq;

  localparam int T = 8;

  logic       clk = 1'b0;
  logic       reset, start, abort, cok;
  logic [7:0] first_page, first_frame, count;
  logic       s_, ad15, busy, done;
  logic [7:0] cfg_page, cfg_frame, err_page, mapped;
  logic [1:0] err;

  memcfg_seq #(.TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .first_page(first_page), .first_frame(first_frame), .count(count),
    .cok(cok), .s_(s_), .ad15(ad15), .cfg_page(cfg_page),
    .cfg_frame(cfg_frame), .busy(busy), .done(done), .err(err),
    .err_page(err_page), .mapped(mapped)
  );

  always #5 clk = ~clk;

  typedef struct { int page; int frame; int len; } cmd_t;
  typedef struct { int err; int err_page; int mapped; } res_t;

  cmd_t cmd_q[$];
  res_t res_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en = 1'b1;

  // Responder: acknowledges after seeing s_ low for `lat` cycles, releases
  // one cycle after s_ rises unless `stuck`.
  int   lat = 1;
  bit   stuck = 1'b0;
  logic s_mid = 1'b1;
  int   low_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    s_mid = s_;
  end

  initial begin
    cok = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        cok = 1'b0;
        low_cnt = 0;
      end else if (s_mid === 1'b0) begin
        low_cnt++;
        if (low_cnt >= lat) cok = 1'b1;
      end else begin
        low_cnt = 0;
        if (!stuck) cok = 1'b0;
      end
    end
  end

  // Monitor: compares strobed commands and final status against the queues.
  initial begin
    bit   prev_s = 1'b1;
    bit   prev_done = 1'b0;
    bit   in_str = 1'b0;
    int   len = 0;
    cmd_t c;
    res_t r;
    c = '{0, 0, 0};
    forever begin
      @(negedge clk);
      if (!mon_en || reset) begin
        in_str = 1'b0;
      end else begin
        if (prev_s && !s_) begin
          if (cmd_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_strobe: got page %0d, none expected", cfg_page);
          end else begin
            c = cmd_q.pop_front();
            check("cmd_page", cfg_page, c.page);
            check("cmd_frame", cfg_frame, c.frame);
            check("cmd_ad15", ad15, 1);
            in_str = 1'b1;
            len = 1;
          end
        end else if (!s_ && in_str) begin
          len++;
        end else if (s_ && !prev_s && in_str) begin
          check("strobe_len", len, c.len);
          check("ad15_after_rise", ad15, 1);
          check("page_hold", cfg_page, c.page);
          in_str = 1'b0;
        end
        if (done && !prev_done) begin
          if (res_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_done: got done, no run expected");
          end else begin
            r = res_q.pop_front();
            check("res_err", err, r.err);
            check("res_err_page", err_page, r.err_page);
            check("res_mapped", mapped, r.mapped);
            check("res_busy", busy, 0);
            check("res_ad15", ad15, 0);
          end
        end
      end
      prev_s = s_;
      prev_done = done;
    end
  end

  // Reference: page walk from the command rules.
  task automatic expect_run(input int fp, input int ff, input int cn,
                            input int l, input bit stk);
    int p = fp, f = ff, rem = cn, mp = 0, e = 0, ep = 0;
    if (cn != 0) begin
      while (1) begin
        if (p >= 2) begin
          if (l <= T) begin
            cmd_q.push_back('{p, f, l + 1});
            mp++;
            if (stk) begin e = 2; ep = p; break; end
          end else begin
            cmd_q.push_back('{p, f, T + 1});
            e = 1; ep = p;
            break;
          end
        end
        rem--;
        if (rem == 0 || p == 255) break;
        p++;
        f = (f + 1) & 255;
      end
    end
    res_q.push_back('{e, ep, mp});
  endtask

  // abort_mode: 0 none, 1 pulse on the nth s_ fall, 2 pulse on the nth s_ rise.
  task automatic run(input logic [7:0] fp, input logic [7:0] ff, input logic [7:0] cn,
                     input int abort_mode, input int abort_n);
    int   cycles = 0, falls = 0, rises = 0;
    logic ps;
    @(negedge clk);
    first_page = fp; first_frame = ff; count = cn; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ps = s_;
    do begin
      @(negedge clk);
      cycles++;
      abort = 1'b0;
      if (ps && !s_) begin
        falls++;
        if (abort_mode == 1 && falls == abort_n) abort = 1'b1;
      end
      if (!ps && s_) begin
        rises++;
        if (abort_mode == 2 && rises == abort_n) abort = 1'b1;
      end
      ps = s_;
    end while (done !== 1'b1 && cycles < 2000);
    abort = 1'b0;
    if (done !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL run_timeout: got no done within %0d cycles", cycles);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    first_page = '0; first_frame = '0; count = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_s_", s_, 1);
    check("rst_ad15", ad15, 0);
    check("rst_cfg_page", cfg_page, 0);
    check("rst_cfg_frame", cfg_frame, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_err_page", err_page, 0);
    check("rst_mapped", mapped, 0);

    // Directed runs.
    lat = 1;   expect_run(2, 8'h11, 3, lat, 0);    run(8'd2, 8'h11, 8'd3, 0, 0);
    lat = 1;   expect_run(0, 8'h30, 4, lat, 0);    run(8'd0, 8'h30, 8'd4, 0, 0);
    lat = 1;   expect_run(9, 8'h55, 0, lat, 0);    run(8'd9, 8'h55, 8'd0, 0, 0);
    lat = 1000; expect_run(2, 8'h20, 2, lat, 0);   run(8'd2, 8'h20, 8'd2, 0, 0);
    lat = T;   expect_run(7, 8'h0F, 2, lat, 0);    run(8'd7, 8'h0F, 8'd2, 0, 0);
    lat = 1;   expect_run(254, 8'hFF, 5, lat, 0);  run(8'd254, 8'hFF, 8'd5, 0, 0);

    lat = 1; stuck = 1'b1;
    expect_run(2, 8'h77, 3, lat, 1);
    run(8'd2, 8'h77, 8'd3, 0, 0);
    stuck = 1'b0;
    repeat (3) @(negedge clk);

    // Abort during the second page's strobe: slow responder, so cok is low.
    lat = 4;
    cmd_q.push_back('{2, 8'h40, 5});
    cmd_q.push_back('{3, 8'h41, 1});
    res_q.push_back('{3, 3, 1});
    run(8'd2, 8'h40, 8'd3, 1, 2);

    // Abort during RELEASE takes effect after the handshake.
    lat = 1;
    cmd_q.push_back('{5, 8'hA0, 2});
    res_q.push_back('{3, 5, 1});
    run(8'd5, 8'hA0, 8'd4, 2, 1);

    // Randomized runs.
    for (int i = 0; i < 14; i++) begin
      int fp, ff, cn;
      case ($urandom_range(0, 2))
        0:       fp = $urandom_range(0, 3);
        1:       fp = $urandom_range(250, 255);
        default: fp = $urandom_range(0, 255);
      endcase
      ff  = $urandom_range(0, 255);
      cn  = $urandom_range(0, 6);
      lat = $urandom_range(1, 10);
      expect_run(fp, ff, cn, lat, 0);
      run(8'(fp), 8'(ff), 8'(cn), 0, 0);
    end

    check("cmd_q_empty", cmd_q.size(), 0);
    check("res_q_empty", res_q.size(), 0);

    // Reset mid-strobe forces s_ high and busy low without a clock edge.
    mon_en = 1'b0;
    lat = 1000;
    @(negedge clk);
    first_page = 8'd3; first_frame = 8'h10; count = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20 && s_ !== 1'b0; k++) @(negedge clk);
    check("pre_reset_s_low", s_, 0);
    #2 reset = 1'b1;
    #1;
    check("midrst_s_", s_, 1);
    check("midrst_busy", busy, 0);
    check("midrst_ad15", ad15, 0);
    check("midrst_cfg_page", cfg_page, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("postrst_s_", s_, 1);
    check("postrst_done", done, 0);
    check("postrst_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
